harvos_dma_copy_engine: RTL and testbench

Single-channel word-copy DMA master. It sits directly upstream of the HarvOS DMA firewall and drives its dmem-style master request port. Software-facing control starts a transfer described by source, destination and length. The engine moves data word by word: one read, then one write, repeated, with no overlap. Faults and timeouts reported by the firewall stop the transfer and are latched for software.

---
 rtl/harvos_dma_copy_engine_pkg.sv | 28 ++
 rtl/harvos_dma_copy_engine_if.sv | 23 ++
 rtl/harvos_dma_copy_engine_wdog.sv | 34 +++
 rtl/harvos_dma_copy_engine.sv | 209 ++++++++++++++++++++
 tb/tb_harvos_dma_copy_engine.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/harvos_dma_copy_engine_pkg.sv
// Shared definitions for the HarvOS word-copy DMA engine.
//   state_t      : engine state encoding
//   ERR_*        : values reported on err_code
//   WORD_STRIDE  : byte increment between consecutive words
//   word_align() : clears the byte-offset bits of an address
package harvos_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FIN
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_FAULT   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/harvos_dma_copy_engine_if.sv
// dmem-style request/response bus between the copy engine and the firewall.
//   master : engine side (drives req/we/be/addr/wdata, receives rdata/done/fault)
//   slave  : firewall side
interface harvos_dma_copy_engine_if;
  logic        dma_req;
  logic        dma_we;
  logic [3:0]  dma_be;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_done;
  logic        dma_fault;

  modport master (
    output dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    input  dma_rdata, dma_done, dma_fault
  );

  modport slave (
    input  dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    output dma_rdata, dma_done, dma_fault
  );
endinterface

// File: rtl/harvos_dma_copy_engine_wdog.sv
// Wait-state watchdog for the copy engine.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count (asserted in the request cycle)
//   run      : count this cycle (asserted in the wait states)
//   expired  : high in the TIMEOUT_CYCLES-th consecutive wait cycle
module harvos_dma_wdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  // The count holds the number of wait cycles already completed, so the
  // current cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0] LIMIT =
    (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (run) begin
      count_reg <= count_reg + TO_W'(1);
    end
  end

  assign expired = run && (TIMEOUT_CYCLES != 0) && (count_reg == LIMIT);

endmodule

// File: rtl/harvos_dma_copy_engine.sv
// Single-channel word-copy DMA master feeding the HarvOS DMA firewall.
//   clk, rst             : clock, synchronous active-high reset
//   start, abort         : control pulses (start ignored while busy)
//   cfg_src/dst/len      : transfer description, latched on accepted start
//   busy, done_pulse     : transfer in progress / one-cycle completion strobe
//   err_code, err_addr   : latched result of the last transfer
//   words_done           : words whose write completed successfully
//   dma                  : master side of the firewall request bus
module harvos_dma_copy_engine
  import harvos_dma_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [31:0]                cfg_src,
  input  logic [31:0]                cfg_dst,
  input  logic [LEN_W-1:0]           cfg_len,
  output logic                       busy,
  output logic                       done_pulse,
  output logic [1:0]                 err_code,
  output logic [31:0]                err_addr,
  output logic [LEN_W-1:0]           words_done,
  harvos_dma_copy_engine_if.master   dma
);

  state_t           state_reg, state_next;
  logic [31:0]      src_reg, src_next;
  logic [31:0]      dst_reg, dst_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [31:0]      data_reg, data_next;
  logic [LEN_W-1:0] words_reg, words_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic [31:0]      err_addr_reg, err_addr_next;
  logic             abort_pend_reg, abort_pend_next;
  logic             req_reg, req_next;
  logic             we_reg, we_next;
  logic [31:0]      addr_reg, addr_next;
  logic             wdog_clr, wdog_run, wdog_expired;

  harvos_dma_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdog_clr),
    .run     (wdog_run),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      data_reg       <= '0;
      words_reg      <= '0;
      err_code_reg   <= ERR_OK;
      err_addr_reg   <= '0;
      abort_pend_reg <= 1'b0;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      src_reg        <= src_next;
      dst_reg        <= dst_next;
      len_reg        <= len_next;
      data_reg       <= data_next;
      words_reg      <= words_next;
      err_code_reg   <= err_code_next;
      err_addr_reg   <= err_addr_next;
      abort_pend_reg <= abort_pend_next;
      req_reg        <= req_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
    end
  end

  // Bus outputs are loaded on entry to a REQ state, so they are registered
  // and stay put through the following WAIT state.
  always_comb begin
    state_next      = state_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    len_next        = len_reg;
    data_next       = data_reg;
    words_next      = words_reg;
    err_code_next   = err_code_reg;
    err_addr_next   = err_addr_reg;
    abort_pend_next = abort_pend_reg;
    req_next        = 1'b0;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdog_clr        = 1'b0;
    wdog_run        = 1'b0;

    if (abort && state_reg != IDLE) begin
      abort_pend_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          src_next        = word_align(cfg_src);
          dst_next        = word_align(cfg_dst);
          len_next        = cfg_len;
          words_next      = '0;
          err_code_next   = ERR_OK;
          err_addr_next   = '0;
          abort_pend_next = 1'b0;
          if (cfg_len == '0) begin
            state_next = FIN;
          end else begin
            state_next = RD_REQ;
            req_next   = 1'b1;
            we_next    = 1'b0;
            addr_next  = word_align(cfg_src);
          end
        end
      end
      RD_REQ: begin
        wdog_clr   = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        wdog_run = 1'b1;
        // A completion in the expiry cycle wins over the timeout.
        if (dma.dma_done) begin
          if (dma.dma_fault) begin
            err_code_next = ERR_FAULT;
            err_addr_next = src_reg;
            state_next    = FIN;
          end else begin
            data_next  = dma.dma_rdata;
            state_next = WR_REQ;
            req_next   = 1'b1;
            we_next    = 1'b1;
            addr_next  = dst_reg;
          end
        end else if (wdog_expired) begin
          err_code_next = ERR_TIMEOUT;
          err_addr_next = addr_reg;
          state_next    = FIN;
        end
      end
      WR_REQ: begin
        wdog_clr   = 1'b1;
        state_next = WR_WAIT;
      end
      WR_WAIT: begin
        wdog_run = 1'b1;
        if (dma.dma_done) begin
          if (dma.dma_fault) begin
            err_code_next = ERR_FAULT;
            err_addr_next = dst_reg;
            state_next    = FIN;
          end else begin
            src_next   = src_reg + WORD_STRIDE;
            dst_next   = dst_reg + WORD_STRIDE;
            len_next   = len_reg - LEN_W'(1);
            words_next = words_reg + LEN_W'(1);
            // The last word always finishes OK, even with an abort pending.
            if (len_reg == LEN_W'(1)) begin
              state_next = FIN;
            end else if (abort_pend_reg || abort) begin
              err_code_next = ERR_ABORT;
              state_next    = FIN;
            end else begin
              state_next = RD_REQ;
              req_next   = 1'b1;
              we_next    = 1'b0;
              addr_next  = src_reg + WORD_STRIDE;
            end
          end
        end else if (wdog_expired) begin
          err_code_next = ERR_TIMEOUT;
          err_addr_next = addr_reg;
          state_next    = FIN;
        end
      end
      FIN: begin
        abort_pend_next = 1'b0;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy          = (state_reg != IDLE) && (state_reg != FIN);
  assign done_pulse    = (state_reg == FIN);
  assign err_code      = err_code_reg;
  assign err_addr      = err_addr_reg;
  assign words_done    = words_reg;
  assign dma.dma_req   = req_reg;
  assign dma.dma_we    = we_reg;
  assign dma.dma_be    = 4'hF;
  assign dma.dma_addr  = addr_reg;
  assign dma.dma_wdata = data_reg;

endmodule

// File: tb/tb_harvos_dma_copy_engine.sv
// Self-checking bench for harvos_dma_copy_engine: a table of transfer
// vectors applied against a behavioural firewall responder, plus directed
// sequences for reset state and reset in the middle of a transfer.
module tb_harvos_dma_copy_engine;
  import harvos_dma_pkg::*;

  localparam int LEN_W = 16;
  localparam int TMO   = 16;
  localparam int TO_W  = 5;
  localparam int LOGSZ = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort_main;
  logic             abort_resp;
  logic             abort;
  logic [31:0]      cfg_src, cfg_dst;
  logic [LEN_W-1:0] cfg_len;
  logic             busy, done_pulse;
  logic [1:0]       err_code;
  logic [31:0]      err_addr;
  logic [LEN_W-1:0] words_done;

  assign abort = abort_main | abort_resp;

  harvos_dma_copy_engine_if dma();

  harvos_dma_copy_engine #(
    .LEN_W          (LEN_W),
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (TO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_src    (cfg_src),
    .cfg_dst    (cfg_dst),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .done_pulse (done_pulse),
    .err_code   (err_code),
    .err_addr   (err_addr),
    .words_done (words_done),
    .dma        (dma)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // Responder configuration (written by the main sequence only)
  logic [31:0] wr_block_below;
  logic        rd_block_en;
  logic [31:0] rd_block_from;
  bit          hang;
  int          abort_read_n;
  int          resp_delay;

  // Responder state and transaction log (written by the responder only)
  int          n_req   = 0;
  int          n_reads = 0;
  bit          pend    = 1'b0;
  int          pcnt    = 0;
  logic        p_we;
  logic [31:0] p_addr;
  logic        req_we_log    [LOGSZ];
  logic [31:0] req_addr_log  [LOGSZ];
  logic [31:0] req_wdata_log [LOGSZ];
  int          req_cyc_log   [LOGSZ];

  // Firewall model: answers each request after resp_delay idle cycles,
  // faults writes below wr_block_below and reads at/above rd_block_from.
  always @(posedge clk) begin
    #1;
    abort_resp    = 1'b0;
    dma.dma_done  = 1'b0;
    dma.dma_fault = 1'b0;
    dma.dma_rdata = 32'h0;
    if (rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (pcnt == 0) begin
        dma.dma_done = 1'b1;
        if (p_we) begin
          dma.dma_fault = (p_addr < wr_block_below);
        end else begin
          dma.dma_fault = rd_block_en && (p_addr >= rd_block_from);
          dma.dma_rdata = mem_fn(p_addr);
        end
        pend = 1'b0;
      end else begin
        pcnt = pcnt - 1;
      end
    end
    if (!rst && dma.dma_req === 1'b1) begin
      check("req_overlap", {31'b0, pend}, 32'h0);
      if (n_req < LOGSZ) begin
        req_we_log[n_req]    = dma.dma_we;
        req_addr_log[n_req]  = dma.dma_addr;
        req_wdata_log[n_req] = dma.dma_wdata;
        req_cyc_log[n_req]   = cyc;
      end
      n_req = n_req + 1;
      if (!dma.dma_we) begin
        n_reads = n_reads + 1;
        if (n_reads == abort_read_n) abort_resp = 1'b1;
      end
      if (!hang) begin
        pend   = 1'b1;
        pcnt   = resp_delay;
        p_we   = dma.dma_we;
        p_addr = dma.dma_addr;
      end
    end
  end

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      wr_below;
    logic             rd_en;
    logic [31:0]      rd_from;
    bit               hang;
    int               abort_rd;     // abort pulsed at this read request (0 = none)
    bit               abort_start;  // abort pulsed together with start
    logic [1:0]       e_err;
    logic [31:0]      e_addr;
    logic [LEN_W-1:0] e_words;
    int               e_nreq;
  } vec_t;

  vec_t vecs [11];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {31'b0, busy}, 32'h0);
    check({tag, "_done"},  {31'b0, done_pulse}, 32'h0);
    check({tag, "_err"},   {30'b0, err_code}, 32'h0);
    check({tag, "_eaddr"}, err_addr, 32'h0);
    check({tag, "_words"}, {16'b0, words_done}, 32'h0);
    check({tag, "_req"},   {31'b0, dma.dma_req}, 32'h0);
    check({tag, "_we"},    {31'b0, dma.dma_we}, 32'h0);
    check({tag, "_be"},    {28'b0, dma.dma_be}, 32'hF);
    check({tag, "_addr"},  dma.dma_addr, 32'h0);
    check({tag, "_wdata"}, dma.dma_wdata, 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          base_req, nreq, s, d, k, nchk;
    logic [31:0] ea, src_al, dst_al;
    wr_block_below = v.wr_below;
    rd_block_en    = v.rd_en;
    rd_block_from  = v.rd_from;
    hang           = v.hang;
    base_req       = n_req;
    abort_read_n   = (v.abort_rd > 0) ? n_reads + v.abort_rd : -1;
    src_al         = {v.src[31:2], 2'b00};
    dst_al         = {v.dst[31:2], 2'b00};

    @(negedge clk);
    start      = 1'b1;
    cfg_src    = v.src;
    cfg_dst    = v.dst;
    cfg_len    = v.len;
    abort_main = v.abort_start;
    s          = cyc;
    @(negedge clk);
    start      = 1'b0;
    abort_main = 1'b0;
    if (v.e_nreq > 0) check("busy_after_start", {31'b0, busy}, 32'h1);

    k = 0;
    while (done_pulse !== 1'b1 && k < 400) begin
      @(negedge clk);
      k = k + 1;
    end
    d    = cyc;
    nreq = n_req - base_req;
    check("done_seen", {31'b0, done_pulse}, 32'h1);
    check("busy_at_done", {31'b0, busy}, 32'h0);
    check("err_code", {30'b0, err_code}, {30'b0, v.e_err});
    check("err_addr", err_addr, v.e_addr);
    check("words_done", {16'b0, words_done}, {16'b0, v.e_words});
    check("req_count", nreq, v.e_nreq);
    // done_pulse rises in the cycle right after the start cycle, i.e. it is
    // sampled on the second rising edge after start was raised.
    if (v.len == 0) check("len0_latency", d - s, 1);
    // 16 wait cycles follow the read request, FIN is the 17th cycle after it.
    if (v.hang) check("timeout_latency", d - req_cyc_log[base_req], 17);

    nchk = (nreq < v.e_nreq) ? nreq : v.e_nreq;
    for (int i = 0; i < nchk; i++) begin
      ea = ((i % 2) == 0) ? src_al + 32'(i / 2) * 32'd4 : dst_al + 32'(i / 2) * 32'd4;
      check("txn_we", {31'b0, req_we_log[base_req + i]}, 32'(i % 2));
      check("txn_addr", req_addr_log[base_req + i], ea);
      if ((i % 2) == 1)
        check("txn_wdata", req_wdata_log[base_req + i], mem_fn(req_addr_log[base_req + i - 1]));
    end

    @(negedge clk);
    check("done_one_cycle", {31'b0, done_pulse}, 32'h0);
    check("err_hold", {30'b0, err_code}, {30'b0, v.e_err});
    $display("vector %0d: src=%h dst=%h len=%0d -> err=%0d err_addr=%h words=%0d reqs=%0d",
             idx, v.src, v.dst, v.len, err_code, err_addr, words_done, nreq);
    hang         = 1'b0;
    abort_read_n = -1;
  endtask

  initial begin
    int k;
    rst            = 1'b1;
    start          = 1'b0;
    abort_main     = 1'b0;
    cfg_src        = '0;
    cfg_dst        = '0;
    cfg_len        = '0;
    wr_block_below = '0;
    rd_block_en    = 1'b0;
    rd_block_from  = '0;
    hang           = 1'b0;
    abort_read_n   = -1;
    resp_delay     = 0;

    vecs[0]  = '{32'h0000_8000, 32'h0000_9000, 16'd4, 32'h0,      1'b0, 32'h0, 1'b0, 0, 1'b0, ERR_OK,      32'h0,         16'd4, 8};
    vecs[1]  = '{32'h0000_8000, 32'h0000_9000, 16'd0, 32'h0,      1'b0, 32'h0, 1'b0, 0, 1'b0, ERR_OK,      32'h0,         16'd0, 0};
    vecs[2]  = '{32'h0000_8000, 32'h0000_0100, 16'd3, 32'h4000,   1'b0, 32'h0, 1'b0, 0, 1'b0, ERR_FAULT,   32'h0000_0100, 16'd0, 2};
    vecs[3]  = '{32'h0000_A000, 32'h0000_B000, 16'd5, 32'h0,      1'b0, 32'h0, 1'b0, 2, 1'b0, ERR_ABORT,   32'h0,         16'd2, 4};
    vecs[4]  = '{32'h0000_A000, 32'h0000_B000, 16'd2, 32'h0,      1'b0, 32'h0, 1'b0, 2, 1'b0, ERR_OK,      32'h0,         16'd2, 4};
    vecs[5]  = '{32'hC000_0010, 32'h0000_9000, 16'd3, 32'h0,      1'b0, 32'h0, 1'b1, 0, 1'b0, ERR_TIMEOUT, 32'hC000_0010, 16'd0, 1};
    vecs[6]  = '{32'h0000_8003, 32'h0000_9002, 16'd1, 32'h0,      1'b0, 32'h0, 1'b0, 0, 1'b0, ERR_OK,      32'h0,         16'd1, 2};
    vecs[7]  = '{32'hFFFF_FFFC, 32'h0000_A000, 16'd2, 32'h0,      1'b0, 32'h0, 1'b0, 0, 1'b0, ERR_OK,      32'h0,         16'd2, 4};
    vecs[8]  = '{32'hF000_0000, 32'h0000_9000, 16'd2, 32'h0,      1'b1, 32'hF000_0000, 1'b0, 0, 1'b0, ERR_FAULT, 32'hF000_0000, 16'd0, 1};
    vecs[9]  = '{32'h0000_8000, 32'h0000_9000, 16'd2, 32'h0,      1'b0, 32'h0, 1'b0, 0, 1'b1, ERR_OK,      32'h0,         16'd2, 4};
    vecs[10] = '{32'h0000_8100, 32'h0000_9100, 16'd2, 32'h0,      1'b0, 32'h0, 1'b0, 0, 1'b0, ERR_OK,      32'h0,         16'd2, 4};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    $display("reset state checked");
    rst = 1'b0;

    // Abort in IDLE must be ignored: vector 0 afterwards must still be OK.
    @(negedge clk);
    abort_main = 1'b1;
    @(negedge clk);
    abort_main = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while the first write is outstanding.
    resp_delay = 3;
    @(negedge clk);
    start   = 1'b1;
    cfg_src = 32'h0000_8000;
    cfg_dst = 32'h0000_9000;
    cfg_len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(dma.dma_we === 1'b1 && dma.dma_req === 1'b0 && busy === 1'b1) && k < 100) begin
      @(negedge clk);
      k = k + 1;
    end
    check("reached_wr_wait", {31'b0, (k < 100)}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst        = 1'b0;
    resp_delay = 0;
    $display("reset during write wait: busy=%0d err=%0d words=%0d", busy, err_code, words_done);
    run_vec(10, vecs[10]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
